// File: rtl/dmem_pkg.sv
// Shared types for the data-side router: route/port state and CPU access-size encodings.
package dmem_pkg;

  typedef enum logic [1:0] {
    RT_IDLE = 2'd0,
    RT_C    = 2'd1,
    RT_U    = 2'd2
  } route_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/osd_counter.sv
// Saturating up/down counter of outstanding transactions; inc and dec together hold the count.
module osd_counter #(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [2:0] o_cnt,
  output logic       o_zero,
  output logic       o_full
);

  localparam logic [2:0] MAX_CNT = 3'(MAX);

  logic [2:0] r_cnt;

  // NOTE: state registers use non-blocking assignment and clear on the asynchronous reset edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + 3'd1;
    end else if (i_dec && !i_inc && !o_zero) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == 3'd0);
  assign o_full = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_router.sv
// Steers physical-address CPU data requests to the cache or uncached port and keeps
// responses in issue order by never having both ports outstanding at once.
module dmem_router
  import dmem_pkg::*;
#(
  parameter int MAX_OSD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_uncache,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        c_req,
  output logic        c_wr,
  output logic [1:0]  c_size,
  output logic [31:0] c_addr,
  output logic [3:0]  c_wstrb,
  output logic [31:0] c_wdata,
  input  logic        c_addr_ok,
  input  logic        c_data_ok,
  input  logic [31:0] c_rdata,
  output logic        u_req,
  output logic        u_wr,
  output logic [1:0]  u_size,
  output logic [31:0] u_addr,
  output logic [3:0]  u_wstrb,
  output logic [31:0] u_wdata,
  input  logic        u_addr_ok,
  input  logic        u_data_ok,
  input  logic [31:0] u_rdata,
  output logic        err_stray
);

  route_e      r_state;
  route_e      w_state_nxt;
  route_e      w_tgt;
  logic [2:0]  w_cnt;
  logic        w_zero;
  logic        w_full;
  logic        w_fwd;
  logic        w_accept;
  logic        w_retire;
  logic        w_act_data_ok;
  logic [31:0] w_act_rdata;
  logic        w_stray;
  logic        w_next_zero;
  logic        r_err_stray;

  assign w_tgt = cpu_uncache ? RT_U : RT_C;

  // Request fields are broadcast; only the req strobe selects the port.
  assign c_wr    = cpu_wr;
  assign c_size  = cpu_size;
  assign c_addr  = cpu_addr;
  assign c_wstrb = cpu_wstrb;
  assign c_wdata = cpu_wdata;
  assign u_wr    = cpu_wr;
  assign u_size  = cpu_size;
  assign u_addr  = cpu_addr;
  assign u_wstrb = cpu_wstrb;
  assign u_wdata = cpu_wdata;

  osd_counter #(.MAX(MAX_OSD)) u_osd (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_accept),
    .i_dec  (w_retire),
    .o_cnt  (w_cnt),
    .o_zero (w_zero),
    .o_full (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_act_data_ok = 1'b0;
    w_act_rdata   = 32'd0;
    w_fwd         = 1'b0;
    c_req         = 1'b0;
    u_req         = 1'b0;
    unique case (r_state)
      RT_C: begin
        w_act_data_ok = c_data_ok;
        w_act_rdata   = c_rdata;
      end
      RT_U: begin
        w_act_data_ok = u_data_ok;
        w_act_rdata   = u_rdata;
      end
      default: ;
    endcase

    // A full port can still issue when one of its requests retires this same cycle.
    if (r_state == RT_IDLE) begin
      w_fwd = 1'b1;
    end else if (r_state == w_tgt) begin
      w_fwd = !w_full || w_act_data_ok;
    end

    if (w_fwd) begin
      c_req = cpu_req && (w_tgt == RT_C);
      u_req = cpu_req && (w_tgt == RT_U);
    end

    cpu_addr_ok = c_req ? c_addr_ok : (u_req ? u_addr_ok : 1'b0);
    w_accept    = cpu_addr_ok;
    w_retire    = w_act_data_ok && !w_zero;
    cpu_data_ok = w_retire;
    cpu_rdata   = w_retire ? w_act_rdata : 32'd0;
    w_stray     = (c_data_ok && !(r_state == RT_C && !w_zero)) ||
                  (u_data_ok && !(r_state == RT_U && !w_zero));
  end

  assign w_next_zero = (w_zero && !w_accept) ||
                       ((w_cnt == 3'd1) && w_retire && !w_accept);

  always_comb begin
    w_state_nxt = r_state;
    if (w_next_zero) begin
      w_state_nxt = RT_IDLE;
    end else if (r_state == RT_IDLE && w_accept) begin
      w_state_nxt = w_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_stray <= 1'b0;
    end else if (w_stray) begin
      r_err_stray <= 1'b1;
    end
  end

  assign err_stray = r_err_stray;

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: routing, fill-to-limit, port switch, stray and reset cases.
module tb_dmem_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, cpu_uncache;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        c_req, c_wr, c_addr_ok, c_data_ok;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_wstrb;
  logic        u_req, u_wr, u_addr_ok, u_data_ok;
  logic [1:0]  u_size;
  logic [31:0] u_addr, u_wdata, u_rdata;
  logic [3:0]  u_wstrb;
  logic        err_stray;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_C    = 32'd1;
  localparam logic [31:0] ST_U    = 32'd2;

  dmem_router #(.MAX_OSD(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_uncache(cpu_uncache), .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .c_req(c_req), .c_wr(c_wr), .c_size(c_size), .c_addr(c_addr), .c_wstrb(c_wstrb),
    .c_wdata(c_wdata), .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_rdata(c_rdata),
    .u_req(u_req), .u_wr(u_wr), .u_size(u_size), .u_addr(u_addr), .u_wstrb(u_wstrb),
    .u_wdata(u_wdata), .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok), .u_rdata(u_rdata),
    .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave time for inputs to be driven away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wr = 0; cpu_size = 2'd2; cpu_addr = 0; cpu_uncache = 0;
    cpu_wstrb = 0; cpu_wdata = 0;
    c_addr_ok = 0; c_data_ok = 0; c_rdata = 0;
    u_addr_ok = 0; u_data_ok = 0; u_rdata = 0;
  endtask

  task automatic cached_req(input logic [31:0] addr);
    cpu_req = 1; cpu_uncache = 0; cpu_addr = addr; c_addr_ok = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    check("rst_addr_ok", 32'(cpu_addr_ok), 0);
    check("rst_data_ok", 32'(cpu_data_ok), 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", 32'(err_stray), 0);
    check("rst_state", 32'(dut.r_state), ST_IDLE);
    rst = 0;
    step();

    // Cached load, response two cycles later.
    cached_req(32'h1FC0_0000); #2;
    check("ld_c_req", 32'(c_req), 1);
    check("ld_u_req", 32'(u_req), 0);
    check("ld_addr_ok", 32'(cpu_addr_ok), 1);
    check("ld_c_addr", c_addr, 32'h1FC0_0000);
    step(); idle_inputs(); #2;
    check("ld_wait_dok", 32'(cpu_data_ok), 0);
    check("ld_osd1", 32'(dut.w_cnt), 1);
    step(); c_data_ok = 1; c_rdata = 32'hDEAD_BEEF; #2;
    check("ld_dok", 32'(cpu_data_ok), 1);
    check("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
    step(); idle_inputs(); #2;
    check("ld_osd0", 32'(dut.w_cnt), 0);
    check("ld_idle", 32'(dut.r_state), ST_IDLE);
    check("ld_rdata0", cpu_rdata, 0);

    // Three back-to-back cached loads against a limit of two.
    step(); cached_req(32'h0000_0100); #2;
    check("fill_a0", 32'(cpu_addr_ok), 1);
    step(); cached_req(32'h0000_0104); #2;
    check("fill_a1", 32'(cpu_addr_ok), 1);
    step(); cached_req(32'h0000_0108); #2;
    check("fill_a2_held", 32'(cpu_addr_ok), 0);
    check("fill_c_req_held", 32'(c_req), 0);
    step(); c_data_ok = 1; c_rdata = 32'h0000_0001; #2;
    check("fill_a2_retire_issue", 32'(cpu_addr_ok), 1);
    check("fill_dok0", 32'(cpu_data_ok), 1);
    step(); cpu_req = 0; c_rdata = 32'h0000_0002; #2;
    check("fill_osd_full", 32'(dut.w_cnt), 2);
    step(); c_rdata = 32'h0000_0003; #2;
    check("fill_osd1", 32'(dut.w_cnt), 1);
    check("fill_rdata3", cpu_rdata, 32'h0000_0003);
    step(); idle_inputs(); #2;
    check("fill_osd0", 32'(dut.w_cnt), 0);
    check("fill_err", 32'(err_stray), 0);

    // Cached store outstanding, then an uncached load must wait for the drain.
    step(); cached_req(32'h0000_0200); cpu_wr = 1; cpu_wstrb = 4'hF; cpu_wdata = 32'h1234_5678; #2;
    check("sw_st_ok", 32'(cpu_addr_ok), 1);
    check("sw_c_wdata", c_wdata, 32'h1234_5678);
    step(); idle_inputs();
    cpu_req = 1; cpu_uncache = 1; cpu_addr = 32'h1FAF_0000; u_addr_ok = 1; #2;
    check("sw_u_held", 32'(u_req), 0);
    check("sw_ok_held", 32'(cpu_addr_ok), 0);
    step(); #2;
    check("sw_u_held2", 32'(u_req), 0);
    step(); c_data_ok = 1; c_rdata = 32'h0000_00AA; #2;
    check("sw_st_dok", 32'(cpu_data_ok), 1);
    check("sw_u_held3", 32'(u_req), 0);
    step(); c_data_ok = 0; c_rdata = 0; #2;
    check("sw_u_req", 32'(u_req), 1);
    check("sw_c_req", 32'(c_req), 0);
    check("sw_u_addr", u_addr, 32'h1FAF_0000);
    check("sw_ld_ok", 32'(cpu_addr_ok), 1);
    step(); idle_inputs(); u_data_ok = 1; u_rdata = 32'hCAFE_F00D; #2;
    check("sw_ld_state", 32'(dut.r_state), ST_U);
    check("sw_ld_dok", 32'(cpu_data_ok), 1);
    check("sw_ld_rdata", cpu_rdata, 32'hCAFE_F00D);
    step(); idle_inputs(); #2;
    check("sw_idle", 32'(dut.r_state), ST_IDLE);

    // Accept and retire in the same cycle at osd = 1.
    step(); cached_req(32'h0000_0300); #2;
    step(); cached_req(32'h0000_0304); c_data_ok = 1; c_rdata = 32'h0000_0077; #2;
    check("ar_ok", 32'(cpu_addr_ok), 1);
    check("ar_dok", 32'(cpu_data_ok), 1);
    step(); idle_inputs(); #2;
    check("ar_osd", 32'(dut.w_cnt), 1);
    check("ar_state", 32'(dut.r_state), ST_C);
    c_data_ok = 1;
    step(); idle_inputs(); #2;
    check("ar_drained", 32'(dut.w_cnt), 0);

    // Stray response while idle.
    step(); u_data_ok = 1; u_rdata = 32'h5555_5555; #2;
    check("stray_dok", 32'(cpu_data_ok), 0);
    check("stray_rdata", cpu_rdata, 0);
    step(); idle_inputs(); #2;
    check("stray_err", 32'(err_stray), 1);
    step(); #2;
    check("stray_sticky", 32'(err_stray), 1);

    // Reset with two outstanding, then a late response.
    step(); cached_req(32'h0000_0400); #2;
    step(); cached_req(32'h0000_0404); #2;
    step(); idle_inputs(); #2;
    check("mid_osd2", 32'(dut.w_cnt), 2);
    rst = 1; #1;
    check("mid_rst_osd", 32'(dut.w_cnt), 0);
    check("mid_rst_state", 32'(dut.r_state), ST_IDLE);
    check("mid_rst_err", 32'(err_stray), 0);
    check("mid_rst_c_req", 32'(c_req), 0);
    check("mid_rst_dok", 32'(cpu_data_ok), 0);
    step(); rst = 0;
    step(); c_data_ok = 1; c_rdata = 32'h0BAD_0BAD; #2;
    check("late_dok", 32'(cpu_data_ok), 0);
    step(); idle_inputs(); #2;
    check("late_err", 32'(err_stray), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_router.md
# dmem_router

Data-side request router sitting directly downstream of the virtual-to-physical address mapper. It takes the CPU's SRAM-like data requests, already carrying a physical address and an uncache flag, and steers each one to either the data-cache port or the uncached bus port. It tracks outstanding transactions so that responses return to the CPU in issue order.

## Interface
- MAX_OSD, default 2: maximum outstanding accepted-but-unanswered requests; range 1..7.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request valid.
- cpu_wr  in  1  1 = store, 0 = load.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_addr  in  32  physical address (mapper output).
- cpu_uncache  in  1  mapper uncache flag: 1 routes to the U port, 0 to the C port.
- cpu_wstrb  in  4  byte enables.
- cpu_wdata  in  32  store data.
- cpu_addr_ok  out  1  request accepted this cycle.
- cpu_data_ok  out  1  one-cycle response pulse.
- cpu_rdata  out  32  load data, valid with cpu_data_ok.
- c_req, c_wr, c_size, c_addr, c_wstrb, c_wdata  out  1/1/2/32/4/32  cache-port request.
- c_addr_ok, c_data_ok  in  1  cache-port handshake.
- c_rdata  in  32  cache-port read data.
- u_* ports: identical set for the uncached port.
- err_stray  out  1  sticky flag: a data_ok arrived with nothing outstanding on that port.

## Operation
- Handshake: a request is accepted when req and addr_ok are both high in the same cycle. Every accepted request, load or store, gets exactly one data_ok.
- State machine {IDLE, BUSY_C, BUSY_U} plus counter osd (3 bits).
  - IDLE: osd = 0.
  - BUSY_C / BUSY_U: osd ≥ 1, and every outstanding request targets that port.
- Target of the current request: tgt = cpu_uncache ? U : C.
- Forwarding is allowed (fwd = 1) when any of these holds:
  - state is IDLE;
  - state matches tgt and osd < MAX_OSD;
  - state matches tgt, osd = MAX_OSD, and the active port's data_ok is high this cycle. This is a same-cycle retire-and-issue.
- When fwd = 1, the target port gets x_req = cpu_req. All request fields pass through unchanged to both ports. The non-target port's req is 0.
- cpu_addr_ok = fwd & (tgt port's addr_ok).
- Target switch: a request to the other port is held (req not forwarded, addr_ok = 0) until osd reaches 0. The FSM returns to IDLE first. The new target is forwarded in the IDLE cycle, combinationally.
- Responses:
  - cpu_data_ok = active port's data_ok, qualified by osd ≠ 0.
  - cpu_rdata = active port's rdata, or 0 when cpu_data_ok = 0.
- Counter update per cycle is osd + accept − retire.
  - Accept and retire in the same cycle: osd unchanged.
  - State becomes IDLE when next osd = 0. It becomes BUSY_tgt on an accept from IDLE.
- Stray response: a data_ok on a port that is not active, or with osd = 0, is dropped. It is not forwarded to the CPU and sets err_stray.
- Size/strobe consistency is not checked; it is the CPU's responsibility.

## Timing
- Request path: combinational, 0 cycles of added latency. The request reaches the port in the same cycle as cpu_req.
- Response path: combinational, 0 cycles of added latency.
- Minimum request-to-response time equals the downstream port's latency.
- Throughput: one accept per cycle on a single port. A port switch costs drain time plus 0 extra cycles.
- Reset values, asserted asynchronously:
  - state = IDLE, osd = 0, err_stray = 0;
  - all outputs low;
  - rdata outputs 0.
- Reset mid-transaction: outstanding requests are forgotten. Late data_ok pulses after reset set err_stray and are not forwarded.

## Structure
- Shared package dmem_pkg:
  - route enum {RT_IDLE, RT_C, RT_U};
  - size constants SZ_B = 0, SZ_H = 1, SZ_W = 2.
- One sub-module, osd_counter: a saturating up/down counter with inc, dec, and outputs cnt, zero, full.
- The FSM and muxing stay in dmem_router.

## Test plan
- Cached load: cpu_addr 0x1FC0_0000, uncache = 0, c_addr_ok = 1, c_data_ok after 2 cycles with rdata 0xDEAD_BEEF → c_req high in cycle 0, u_req low, cpu_data_ok pulses once with 0xDEAD_BEEF, osd returns to 0.
- Back-to-back fill to limit: 3 cached loads on consecutive cycles, MAX_OSD = 2, c_data_ok held off → first two accepted, third gets cpu_addr_ok = 0. The third is accepted in the same cycle as the first c_data_ok.
- Port switch: cached store outstanding, then an uncached load to 0x1FAF_0000 → u_req stays 0 until the c_data_ok arrives. u_req rises in the first cycle with osd = 0. Responses arrive in order: store then load.
- Simultaneous accept and retire at osd = 1 → osd stays 1 and state stays BUSY.
- Stray response: u_data_ok pulsed while IDLE → cpu_data_ok stays 0 and err_stray = 1 until rst.
- Reset mid-operation: rst asserted with osd = 2 → all outputs 0 immediately and state IDLE. A subsequent c_data_ok sets err_stray.
